aes_key_sched_ctrl: RTL

Sequencer for AES-128 key expansion. It walks the round index 1..NR and drives the shared round-constant lookup and the shared SubWord S-box. It emits round keys 0..NR one at a time over a valid/ready stream to the cipher round datapath. It sits between the key register and the AES-CTR round pipeline.

---
 rtl/aes_pkg.sv | 13 +
 rtl/aes_key_round.sv | 29 ++
 rtl/aes_key_sched_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared constants and state type for the AES-128 key schedule slice.
// Imported by aes_key_round and aes_key_sched_ctrl.
package aes_pkg;
  localparam int NR_MAX = 10;
  localparam int KW = 128;
  localparam int WW = 32;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } ks_state_t;
endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key expansion step; S-box and rcon are external lookups.
// Purely combinational, shared with any decrypt-side key unit.
import aes_pkg::*;

module aes_key_round (
  input  logic [KW-1:0] key,
  input  logic [WW-1:0] sw_out,
  input  logic [WW-1:0] rcon_in,
  output logic [WW-1:0] sw_in,
  output logic [KW-1:0] next_key
);
  logic [WW-1:0] w0, w1, w2, w3;
  logic [WW-1:0] t, n0, n1, n2, n3;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  assign sw_in = {w3[23:0], w3[31:24]};

  assign t  = sw_out ^ rcon_in;
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion sequencer: streams round keys 0..NR over valid/ready.
// Define AES_KS_ABORT_EN to add the abort input.
import aes_pkg::*;

module aes_key_sched_ctrl #(
  parameter int NR = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [127:0]  key_in,
  input  logic          rk_ready,
`ifdef AES_KS_ABORT_EN
  input  logic          abort,
`endif
  output logic          rk_valid,
  output logic [127:0]  rk_data,
  output logic [3:0]    rk_idx,
  output logic [3:0]    rcon_i,
  input  logic [31:0]   rcon_in,
  output logic [31:0]   sw_in,
  input  logic [31:0]   sw_out,
  output logic          busy,
  output logic          done
);
  ks_state_t     state;
  logic [KW-1:0] next_key;
  logic          last;

  aes_key_round u_round (
    .key      (rk_data),
    .sw_out   (sw_out),
    .rcon_in  (rcon_in),
    .sw_in    (sw_in),
    .next_key (next_key)
  );

  assign last   = (rk_idx == 4'(NR));
  assign rcon_i = last ? 4'd0 : rk_idx + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_idx   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
`ifdef AES_KS_ABORT_EN
      if (abort) begin
        state    <= IDLE;
        rk_valid <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b0;
      end else
`endif
      begin
        unique case (state)
          IDLE: begin
            if (start) begin
              rk_data  <= key_in;
              rk_idx   <= '0;
              rk_valid <= 1'b1;
              busy     <= 1'b1;
              state    <= EMIT;
            end
          end
          EMIT: begin
            if (rk_ready) begin
              if (last) begin
                rk_valid <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                state    <= DONE;
              end else begin
                rk_data <= next_key;
                rk_idx  <= rk_idx + 4'd1;
              end
            end
          end
          DONE: begin
            done  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
